// File: rtl/deci_pkg.sv
// rtl/deci_pkg.sv - shared constants and types for the decimator output path
package deci_pkg;

    localparam int PCM_IN_W   = 32;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_SLOT_W = 32;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [PCM_IN_W-1:0] left;
        logic [PCM_IN_W-1:0] right;
    } pcm_pair_t;

endpackage

// File: rtl/pcm_i2s_tx_if.sv
// rtl/pcm_i2s_tx_if.sv - sample pair handshake between decimator and I2S transmitter
interface pcm_i2s_tx_if;
    import deci_pkg::*;

    logic [PCM_IN_W-1:0] pcm_left;
    logic [PCM_IN_W-1:0] pcm_right;
    logic                in_valid;
    logic                in_ready;

    modport master (
        output pcm_left,
        output pcm_right,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  pcm_left,
        input  pcm_right,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/pcm_round_sat.sv
// rtl/pcm_round_sat.sv - gain, round-half-up and saturate one 32-bit sample to DATA_W bits
module pcm_round_sat
    import deci_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAIN_SHIFT = 0
) (
    input  logic [PCM_IN_W-1:0] sample,
    output logic [DATA_W-1:0]   word
);

    localparam int ACC_W   = 40;
    localparam int RND_POS = (DATA_W < PCM_IN_W) ? (PCM_IN_W - 1 - DATA_W) : 0;
    localparam logic signed [ACC_W-1:0] RND   = (DATA_W < PCM_IN_W) ? (ACC_W'(1) << RND_POS) : '0;
    localparam logic signed [ACC_W-1:0] MAX_P = (ACC_W'(1) << (PCM_IN_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MIN_N = -(ACC_W'(1) << (PCM_IN_W - 1));

    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] acc;

    // 40 bits leave headroom for the largest gain, so the clamp sees the true value
    always_comb begin
        ext = {{(ACC_W - PCM_IN_W){sample[PCM_IN_W-1]}}, sample};
        acc = (ext <<< GAIN_SHIFT) + RND;
        if (acc > MAX_P) begin
            word = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (acc < MIN_N) begin
            word = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            word = acc[PCM_IN_W-1 -: DATA_W];
        end
    end

endmodule

// File: rtl/pcm_i2s_tx.sv
// rtl/pcm_i2s_tx.sv - two-pair input FIFO and I2S serializer clocked by the bit clock
module pcm_i2s_tx
    import deci_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SLOT_W     = DEF_SLOT_W,
    parameter int GAIN_SHIFT = 0
) (
    input  logic         deci_bck,
    input  logic         reset,
    pcm_i2s_tx_if.slave  pcm,
    input  logic         clear_flags,
    output logic         sdata,
    output logic         lrck,
    output logic         underrun,
    output logic         overflow
);

    localparam int FRAME = 2 * SLOT_W;
    localparam int CW    = $clog2(FRAME);
    localparam int IW    = $clog2(DATA_W);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int OW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    int                pos;
    logic              sdata_next;
    logic              lrck_next;

    pcm_pair_t         fifo_mem [FIFO_DEPTH];
    pcm_pair_t         head;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [OW-1:0]     occ;
    logic [OW-1:0]     occ_next;
    logic              full;
    logic              empty;
    logic              boundary;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] conv_left;
    logic [DATA_W-1:0] conv_right;
    logic [DATA_W-1:0] tx_left;
    logic [DATA_W-1:0] tx_right;

    assign full         = (occ == OW'(FIFO_DEPTH));
    assign empty        = (occ == '0);
    assign boundary     = (cnt == LAST);
    assign push         = pcm.in_valid && !full;
    assign pop          = boundary && !empty;
    assign pcm.in_ready = !full;
    assign head         = fifo_mem[rd_ptr];

    pcm_round_sat #(.DATA_W(DATA_W), .GAIN_SHIFT(GAIN_SHIFT)) u_rs_left (
        .sample (head.left),
        .word   (conv_left)
    );

    pcm_round_sat #(.DATA_W(DATA_W), .GAIN_SHIFT(GAIN_SHIFT)) u_rs_right (
        .sample (head.right),
        .word   (conv_right)
    );

    // Output bits are chosen from the count they will be shown at; count 0 still
    // reads the previous right word, which is why the wrapped LSB survives the pop.
    always_comb begin
        cnt_next   = boundary ? '0 : cnt + 1'b1;
        pos        = int'(cnt_next);
        lrck_next  = (pos >= SLOT_W);
        sdata_next = 1'b0;
        if ((pos >= 1) && (pos <= DATA_W)) begin
            sdata_next = tx_left[IW'(DATA_W - pos)];
        end else if ((pos >= SLOT_W + 1) && (pos <= SLOT_W + DATA_W)) begin
            sdata_next = tx_right[IW'(SLOT_W + DATA_W - pos)];
        end else if ((pos == 0) && (SLOT_W == DATA_W)) begin
            sdata_next = tx_right[0];
        end

        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge deci_bck) begin
        if (reset) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            tx_left  <= '0;
            tx_right <= '0;
            sdata    <= 1'b0;
            lrck     <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            sdata <= sdata_next;
            lrck  <= lrck_next;
            occ   <= occ_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // With nothing queued the previous pair simply stays in place and repeats
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                tx_left  <= conv_left;
                tx_right <= conv_right;
            end
            underrun <= (boundary && empty) || (underrun && !clear_flags);
            overflow <= (pcm.in_valid && full) || (overflow && !clear_flags);
        end
    end

    always_ff @(posedge deci_bck) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pcm.pcm_left, pcm.pcm_right};
        end
    end

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// tb/tb_pcm_i2s_tx.sv - directed bench for pcm_i2s_tx at default, gain-2 and 16/16 framings
module tb_pcm_i2s_tx;

    logic        clk;
    logic        rst;
    logic        iv;
    logic        clr;
    logic [31:0] pl;
    logic [31:0] pr;
    int          tcnt;
    int          n_checks;
    int          n_errors;

    logic sd_o_m, lr_o_m, ur_m, ov_m;
    logic sd_o_g, lr_o_g, ur_g, ov_g;
    logic sd_o_w, lr_o_w, ur_w, ov_w;

    logic [63:0] sd_m, lr_m, sd_g, sd_w, lr_w;
    logic [63:0] zero64;

    pcm_i2s_tx_if bus_m ();
    pcm_i2s_tx_if bus_g ();
    pcm_i2s_tx_if bus_w ();

    assign bus_m.pcm_left  = pl;
    assign bus_m.pcm_right = pr;
    assign bus_m.in_valid  = iv;
    assign bus_g.pcm_left  = pl;
    assign bus_g.pcm_right = pr;
    assign bus_g.in_valid  = iv;
    assign bus_w.pcm_left  = pl;
    assign bus_w.pcm_right = pr;
    assign bus_w.in_valid  = iv;

    pcm_i2s_tx dut_m (
        .deci_bck(clk), .reset(rst), .pcm(bus_m.slave), .clear_flags(clr),
        .sdata(sd_o_m), .lrck(lr_o_m), .underrun(ur_m), .overflow(ov_m)
    );

    pcm_i2s_tx #(.GAIN_SHIFT(2)) dut_g (
        .deci_bck(clk), .reset(rst), .pcm(bus_g.slave), .clear_flags(clr),
        .sdata(sd_o_g), .lrck(lr_o_g), .underrun(ur_g), .overflow(ov_g)
    );

    pcm_i2s_tx #(.DATA_W(16), .SLOT_W(16)) dut_w (
        .deci_bck(clk), .reset(rst), .pcm(bus_w.slave), .clear_flags(clr),
        .sdata(sd_o_w), .lrck(lr_o_w), .underrun(ur_w), .overflow(ov_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame position: counts alongside the DUT from its reset
    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= (tcnt == 63) ? 0 : tcnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic step_to(input int target);
        for (int g = 0; g < 70 && tcnt != target; g++) step();
    endtask

    function automatic logic [63:0] frame24(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f = '0;
        for (int i = 0; i < 24; i++) begin
            f[1 + i]  = l[23 - i];
            f[33 + i] = r[23 - i];
        end
        return f;
    endfunction

    function automatic logic [63:0] frame16(input logic p0, input logic [15:0] l1, input logic [15:0] r1,
                                            input logic [15:0] l2, input logic [15:0] r2);
        logic [63:0] f = '0;
        f[0]  = p0;
        f[32] = r1[0];
        for (int i = 0; i < 16; i++) begin
            f[1 + i]  = l1[15 - i];
            f[33 + i] = l2[15 - i];
        end
        for (int i = 0; i < 15; i++) begin
            f[17 + i] = r1[15 - i];
            f[49 + i] = r2[15 - i];
        end
        return f;
    endfunction

    task automatic capture(input int push_at, input logic [31:0] l, input logic [31:0] r);
        step_to(0);
        for (int c = 0; c < 64; c++) begin
            if (c != 0) step();
            sd_m[c] = sd_o_m;
            lr_m[c] = lr_o_m;
            sd_g[c] = sd_o_g;
            sd_w[c] = sd_o_w;
            lr_w[c] = lr_o_w;
            if (c == push_at) begin
                iv = 1'b1;
                pl = l;
                pr = r;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        zero64   = '0;
        rst = 1'b1;
        iv  = 1'b0;
        clr = 1'b0;
        pl  = '0;
        pr  = '0;
        repeat (3) @(negedge clk);

        check_eq("rst_in_ready", bus_m.in_ready, 1);
        check_eq("rst_lrck", lr_o_m, 0);
        check_eq("rst_sdata", sd_o_m, 0);
        check_eq("rst_underrun", ur_m, 0);
        check_eq("rst_overflow", ov_m, 0);

        rst = 1'b0;
        iv  = 1'b1;
        pl  = 32'h12345600;
        pr  = 32'hEDCBAA00;
        step();

        capture(-1, '0, '0);
        check_eq("w1_main_sd", sd_m, frame24(24'h123456, 24'hEDCBAA));
        check_eq("w1_main_lr", lr_m, 64'hFFFFFFFF_00000000);
        check_eq("w1_gain_sd", sd_g, frame24(24'h48D158, 24'hB72EA8));
        check_eq("w1_w16_sd", sd_w, frame16(1'b0, 16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC));
        check_eq("w1_w16_lr", lr_w, 64'hFFFF0000_FFFF0000);
        check_eq("w1_underrun", ur_m, 0);

        capture(-1, '0, '0);
        check_eq("w2_repeat_sd", sd_m, frame24(24'h123456, 24'hEDCBAA));
        check_eq("w2_underrun", ur_m, 1);
        capture(-1, '0, '0);
        check_eq("w3_repeat_sd", sd_m, frame24(24'h123456, 24'hEDCBAA));

        clr = 1'b1;
        step();
        check_eq("clr_set_wins", ur_m, 1);
        step();
        clr = 1'b0;
        check_eq("clr_underrun", ur_m, 0);
        check_eq("clr_overflow", ov_m, 0);

        step_to(10);
        iv = 1'b1; pl = 32'h7FFFFF80; pr = 32'h80000000;
        check_eq("ovf_ready_1", bus_m.in_ready, 1);
        step();
        iv = 1'b1; pl = 32'h7FFFFFFF; pr = 32'h5A5B3C00;
        check_eq("ovf_ready_2", bus_m.in_ready, 1);
        step();
        iv = 1'b1; pl = 32'h11111100; pr = 32'h22222200;
        check_eq("ovf_ready_3", bus_m.in_ready, 0);
        check_eq("ovf_before", ov_m, 0);
        step();
        check_eq("ovf_after", ov_m, 1);
        check_eq("ovf_still_full", bus_m.in_ready, 0);

        capture(63, 32'h40000000, 32'hC0000000);
        check_eq("w5_main_sd", sd_m, frame24(24'h7FFFFF, 24'h800000));
        check_eq("w5_gain_sd", sd_g, frame24(24'h7FFFFF, 24'h800000));
        check_eq("w5_w16_wrap", sd_w, frame16(1'b0, 16'h7FFF, 16'h5A5B, 16'h7FFF, 16'h5A5B));

        capture(-1, '0, '0);
        check_eq("w6_main_sd", sd_m, frame24(24'h7FFFFF, 24'h5A5B3C));

        capture(-1, '0, '0);
        check_eq("w7_main_sd", sd_m, frame24(24'h400000, 24'hC00000));
        check_eq("w7_gain_sd", sd_g, frame24(24'h7FFFFF, 24'h800000));
        check_eq("w7_underrun", ur_m, 0);

        step_to(5);
        check_eq("w8_underrun", ur_m, 1);
        iv = 1'b1; pl = 32'h7FFFFF00; pr = 32'h01234500;
        step();
        check_eq("w8_ready", bus_m.in_ready, 1);
        step_to(40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_lrck", lr_o_m, 0);
        check_eq("mid_rst_sdata", sd_o_m, 0);
        check_eq("mid_rst_ready", bus_m.in_ready, 1);
        check_eq("mid_rst_underrun", ur_m, 0);
        check_eq("mid_rst_overflow", ov_m, 0);

        capture(-1, '0, '0);
        check_eq("post_rst_sd", sd_m, zero64);
        check_eq("post_rst_lr", lr_m, 64'hFFFFFFFF_00000000);
        check_eq("post_rst_ur_before", ur_m, 0);
        step();
        check_eq("post_rst_ur_after", ur_m, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcm_i2s_tx.md
PCM_I2S_TX -- requirements
Module: pcm_i2s_tx

Interface
REQ-001 Parameter DATA_W, default 24: output word width, legal 16..32.
REQ-002 Parameter SLOT_W, default 32: bit clocks per channel slot, legal DATA_W..32.
REQ-003 Parameter GAIN_SHIFT, default 0: left-shift applied before rounding, legal 0..7.
REQ-004 deci_bck  in  1: single clock, all logic on rising edge; doubles as output bit clock.
REQ-005 reset  in  1: synchronous, active-high.
REQ-006 pcm_left  in  32: signed left sample from decimator.
REQ-007 pcm_right  in  32: signed right sample from decimator.
REQ-008 in_valid  in  1: sample pair present on pcm_left/pcm_right.
REQ-009 in_ready  out  1: block can accept a pair this cycle.
REQ-010 clear_flags  in  1: clears sticky flags.
REQ-011 sdata  out  1: I2S serial data, MSB first.
REQ-012 lrck  out  1: word select; 0 = left slot, 1 = right slot.
REQ-013 underrun  out  1: sticky, frame started with FIFO empty.
REQ-014 overflow  out  1: sticky, in_valid seen while FIFO full.

Function
REQ-015 A pair transfers when in_valid and in_ready are both high on a rising edge.
REQ-016 Input FIFO is 2 pairs deep; in_ready = not full.
REQ-017 While full, in_valid raises overflow; the offered pair is dropped; FIFO contents are unchanged.
REQ-018 The bit counter runs 0..2*SLOT_W-1 and wraps; lrck = 0 for counts 0..SLOT_W-1 and 1 otherwise.
REQ-019 At count 2*SLOT_W-1 (frame boundary), the head pair pops into the shift registers and is transmitted in the following frame.
REQ-020 If the FIFO is empty at a frame boundary, the last transmitted pair repeats and underrun sets.
REQ-021 If a push and a pop happen in the same cycle, both take effect; occupancy is unchanged.
REQ-022 Conversion per channel:
- sign-extend to 40 bits;
- shift left by GAIN_SHIFT;
- add 2^(31-DATA_W) (round half up);
- saturate to the 32-bit signed range;
- take the top DATA_W bits.
REQ-023 Full-scale boundaries: 32'h7FFFFFFF maps to +max at DATA_W; 32'h80000000 maps to -max-1 (most negative).
REQ-024 I2S framing: the MSB is driven one deci_bck cycle after each lrck edge, i.e. at count 1 (left) and count SLOT_W+1 (right).
REQ-025 Following the MSB, DATA_W-1 further bits are driven; the remaining slot bits are 0.
REQ-026 The LSB of the right word that does not fit in the slot (when SLOT_W = DATA_W) wraps into count 0 of the next frame.
REQ-027 sdata and lrck are registered; they change only on the rising edge; the receiver samples on the falling edge.
REQ-028 Latency: a pair accepted into an empty FIFO at frame count k appears (MSB) 2*SLOT_W-k+1 cycles later.
REQ-029 clear_flags clears both flags; a set event in the same cycle wins (flag stays 1).

Reset
REQ-030 Reset forces the following to 0: bit counter, FIFO pointers and occupancy, shift registers, last-pair registers, sdata, lrck, underrun, overflow.
REQ-031 After reset, in_ready = 1 on the first cycle.
REQ-032 Reset mid-frame aborts the frame; the next frame restarts at count 0 with lrck = 0.
REQ-033 Reset mid-frame discards FIFO contents; the first frame transmits zeros and sets underrun only if still empty at its boundary.

Structure
REQ-034 Shared package deci_pkg holds:
- PCM_IN_W = 32;
- the default DATA_W and SLOT_W;
- the FIFO depth constant.
REQ-035 Rounding/saturation is one combinational sub-module, pcm_round_sat, instantiated once per channel.
REQ-036 The FIFO and the serializer stay inline.

Verification
REQ-037 Push L=32'h12345600, R=32'hEDCBAA00 after reset, DATA_W=24 → left slot carries 24'h123456 and right slot 24'hEDCBAA, MSB at counts 1 and 33.
REQ-038 pcm_left=32'h7FFFFF80, GAIN_SHIFT=0 → rounds to 24'h7FFFFF (saturated, no wrap).
REQ-039 GAIN_SHIFT=2 with 32'h40000000 → 24'h7FFFFF; with 32'hC0000000 → 24'h800000.
REQ-040 Three pushes in consecutive cycles mid-frame → third push sees in_ready=0, overflow=1, first two pairs transmitted in order.
REQ-041 No push for two frames → last pair repeated twice; underrun=1; clear_flags pulse → underrun=0.
REQ-042 Assert reset at count 40 with FIFO holding 1 pair → next cycle lrck=0, sdata=0, in_ready=1, flags 0; post-reset frame is all zeros.
